// File: rtl/wconv_fifo_buf_if.sv
// Bus bundle for the width-converting FIFO: wide write side, narrow read side,
// occupancy levels and sticky error flags.
interface wconv_fifo_buf_if #(
  parameter int WR_DEPTH_WIDTH = 9,
  parameter int WR_DATA_WIDTH  = 256,
  parameter int RD_DATA_WIDTH  = 32
);
  localparam int RATIO    = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int SUB_W    = $clog2(RATIO);
  localparam int RD_LVL_W = WR_DEPTH_WIDTH + SUB_W + 1;

  // Handshake: wr_en is a request qualified by !wr_full and rd_en by !rd_empty,
  // both as seen before the edge; a transfer happens only on an edge where the
  // request and its qualifier are both true. Nothing is queued: a request made
  // while its qualifier is false is dropped and raises the matching sticky flag.
  // rd_data shows the accepted narrow word one cycle later and then holds.
  logic [WR_DATA_WIDTH-1:0]  wr_data;
  logic                      wr_en;
  logic                      wr_full;
  logic                      almost_full;
  logic [WR_DEPTH_WIDTH:0]   wr_water_level;
  logic                      wr_overflow;
  logic                      rd_en;
  logic [RD_DATA_WIDTH-1:0]  rd_data;
  logic                      rd_empty;
  logic                      almost_empty;
  logic [RD_LVL_W-1:0]       rd_water_level;
  logic                      rd_underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, almost_full, wr_water_level, wr_overflow,
    input  rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, almost_full, wr_water_level, wr_overflow,
    output rd_data, rd_empty, almost_empty, rd_water_level, rd_underflow
  );
endinterface

// File: rtl/wconv_fifo_buf.sv
// Single-clock FIFO that stores wide words and hands them out as RATIO narrow
// sub-words, with thresholds, synchronous flush and sticky over/underflow flags.
module wconv_fifo_buf #(
  parameter int WR_DEPTH_WIDTH   = 9,
  parameter int WR_DATA_WIDTH    = 256,
  parameter int RD_DATA_WIDTH    = 32,
  parameter     SUB_ORDER        = "LSB_FIRST",
  parameter int ALMOST_FULL_NUM  = 508,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  wconv_fifo_buf_if.slave   bus
);
  localparam int RATIO     = WR_DATA_WIDTH / RD_DATA_WIDTH;
  localparam int SUB_W     = $clog2(RATIO);
  localparam int SUB_IDX_W = (SUB_W > 0) ? SUB_W : 1;
  localparam int RD_LVL_W  = WR_DEPTH_WIDTH + SUB_W + 1;
  localparam int DEPTH     = 2 ** WR_DEPTH_WIDTH;
  localparam bit MSB_FIRST = (SUB_ORDER == "MSB_FIRST");

  localparam logic [WR_DEPTH_WIDTH:0] WCNT_ONE  = (WR_DEPTH_WIDTH+1)'(1);
  localparam logic [WR_DEPTH_WIDTH:0] WCNT_FULL = (WR_DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [WR_DEPTH_WIDTH:0] WCNT_AF   = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [RD_LVL_W-1:0]     RLVL_AE   = RD_LVL_W'(ALMOST_EMPTY_NUM);
  localparam logic [SUB_IDX_W-1:0]    SUB_LAST  = SUB_IDX_W'(RATIO - 1);
  localparam logic [SUB_IDX_W-1:0]    SUB_ONE   = SUB_IDX_W'(1);

  logic [WR_DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [WR_DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [WR_DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [SUB_IDX_W-1:0]      r_sub_idx;
  logic [WR_DEPTH_WIDTH:0]   r_wcount;
  logic [RD_DATA_WIDTH-1:0]  r_rd_data;
  logic                      r_overflow;
  logic                      r_underflow;

  logic                                 w_full;
  logic                                 w_empty;
  logic                                 w_wr_acc;
  logic                                 w_rd_acc;
  logic                                 w_last_sub;
  logic                                 w_free;
  logic [SUB_IDX_W-1:0]                 w_slice_idx;
  logic [SUB_IDX_W-1:0]                 w_sub_idx_nxt;
  logic [RATIO-1:0][RD_DATA_WIDTH-1:0]  w_rd_slices;
  logic [RD_LVL_W-1:0]                  w_rd_level;
  logic [WR_DEPTH_WIDTH:0]              w_wcount_nxt;

  // A partially read wide word stays counted in r_wcount until its last slice goes.
  assign w_rd_level  = (RD_LVL_W'(r_wcount) << SUB_W) - RD_LVL_W'(r_sub_idx);
  assign w_full      = (r_wcount == WCNT_FULL);
  assign w_empty     = (r_wcount == '0);
  assign w_wr_acc    = bus.wr_en & ~w_full;
  assign w_rd_acc    = bus.rd_en & ~w_empty;
  assign w_last_sub  = (r_sub_idx == SUB_LAST);
  assign w_free      = w_rd_acc & w_last_sub;
  assign w_slice_idx = MSB_FIRST ? (SUB_LAST - r_sub_idx) : r_sub_idx;
  assign w_rd_slices = r_mem[r_rd_ptr];

  always_comb begin
    w_wcount_nxt = r_wcount;
    case ({w_wr_acc, w_free})
      2'b10:   w_wcount_nxt = r_wcount + WCNT_ONE;
      2'b01:   w_wcount_nxt = r_wcount - WCNT_ONE;
      default: w_wcount_nxt = r_wcount;
    endcase
  end

  always_comb begin
    w_sub_idx_nxt = r_sub_idx;
    if (w_rd_acc) w_sub_idx_nxt = w_last_sub ? '0 : (r_sub_idx + SUB_ONE);
  end

  // Storage is never cleared; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sub_idx   <= '0;
      r_wcount    <= '0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sub_idx   <= '0;
      r_wcount    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_data <= w_rd_slices[w_slice_idx];
      if (w_free) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_sub_idx <= w_sub_idx_nxt;
      r_wcount  <= w_wcount_nxt;
      if (bus.wr_en && w_full) r_overflow <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.wr_full        = w_full;
  assign bus.almost_full    = (r_wcount >= WCNT_AF);
  assign bus.wr_water_level = r_wcount;
  assign bus.wr_overflow    = r_overflow;
  assign bus.rd_data        = r_rd_data;
  assign bus.rd_empty       = w_empty;
  assign bus.almost_empty   = (w_rd_level <= RLVL_AE);
  assign bus.rd_water_level = w_rd_level;
  assign bus.rd_underflow   = r_underflow;
endmodule
